phy_tx_arbiter: RTL and testbench
=================================

# phy_tx_arbiter

Packet-granular round-robin arbiter that shares the single GT transmit AXI-stream path between two user requesters. It sits between the user logic and the PHY transmit framer, which inserts the SOF/EOF K-characters. It grants a whole frame at a time and never interleaves beats of different frames. After every frame it enforces a minimum idle gap, which gives the framer room to emit EOF, idle and comma characters. New grants are held off while the link is not up.

## Interface
- GAP_CYCLES, 4: minimum number of GAP-state cycles after each frame's last beat; legal range 0..255.
- i_clk  in  1  clock; every register is clocked on its rising edge.
- r_rst  in  1  reset; asynchronous, active-high. Clock is i_clk.
- i_link_up  in  1  GT link ready (byte-aligned and stable); gates new grants only.
- i_axi_s0_valid / i_axi_s0_last  in  1  requester 0 AXI-stream valid and frame-last flag.
- i_axi_s0_keep  in  4  requester 0 byte enables.
- i_axi_s0_data  in  32  requester 0 data.
- o_axi_s0_ready  out  1  requester 0 ready.
- i_axi_s1_valid, i_axi_s1_last, i_axi_s1_keep, i_axi_s1_data, o_axi_s1_ready: requester 1, with the same widths and meanings as requester 0.
- o_axi_m_valid / o_axi_m_last  out  1  to the framer: valid and frame-last flag.
- o_axi_m_keep  out  4  to the framer: byte enables.
- o_axi_m_data  out  32  to the framer: data.
- i_axi_m_ready  in  1  framer ready.
- o_grant  out  2  one-hot indication of the current owner; 2'b00 when no frame is granted.
- o_keep_err  out  1  one-cycle pulse on an accepted non-last beat whose keep is not 4'b1111.

## Operation
- The FSM has four states: IDLE, ARB, XFER and GAP. The reset state is IDLE.
- IDLE
  - i_link_up=1 → ARB.
- ARB
  - i_link_up=0 → IDLE.
  - Neither valid asserted → stay in ARB.
  - Otherwise select a winner and register it into r_owner, then go to XFER.
  - Winner selection: if only one requester has valid=1, it wins. If both do, the requester pointed to by r_rr_ptr wins.
- XFER: path muxing
  - o_axi_m_{valid,last,keep,data} are driven combinationally from the owning requester's inputs.
  - The owner's ready equals i_axi_m_ready.
  - The non-owner's ready is 0.
- XFER: beat handshake
  - A beat is transferred when o_axi_m_valid & i_axi_m_ready.
  - On a beat with last=1:
    - r_rr_ptr ← the owner's index inverted.
    - o_grant goes to 0 in the next cycle.
    - Next state is GAP, or ARB directly when GAP_CYCLES=0.
- XFER: link loss
  - A drop of i_link_up during XFER does not truncate the frame; the frame runs to its last beat.
  - After that beat, GAP proceeds as normal.
  - The transition out of GAP/ARB then goes to IDLE.
- GAP
  - An 8-bit counter runs from 0 to GAP_CYCLES-1.
  - o_axi_m_valid=0 and both readys are 0.
  - At terminal count: next state is ARB if i_link_up=1, otherwise IDLE.
- Outside XFER: o_axi_m_valid=0, o_axi_m_last=0, o_axi_m_keep=0, o_axi_m_data=0, and both readys are 0.
- Keep checking: o_keep_err is registered. It is set in the cycle after an accepted beat with last=0 and keep≠4'b1111. The beat itself is still forwarded unchanged.
- The block does not modify data or keep.
- A requester that drops valid mid-frame keeps ownership. The arbiter waits for its last beat; there is no timeout.

## Timing
- Reset values:
  - State = IDLE, r_rr_ptr = 0 (requester 0 is preferred first), r_owner = none.
  - Counter = 0, o_grant = 2'b00, o_keep_err = 0.
  - All m-side outputs are 0 and both readys are 0.
- Grant latency: valid seen in an ARB cycle gives o_grant and o_axi_m_valid in the following cycle (1 cycle).
- Data-path latency in XFER is 0 cycles (combinational pass-through). Throughput is 1 beat per cycle while ready=1.
- Frame spacing: for a last-beat handshake in cycle N, with GAP_CYCLES=G≥1 and a pending request:
  - GAP occupies cycles N+1..N+G.
  - ARB is cycle N+G+1.
  - The next first beat can appear at N+G+2.
  - With G=0: ARB at N+1, first beat at N+2.
- When both requesters stay continuously valid, grants strictly alternate 0,1,0,1…
- Asserting r_rst at any point, including mid-frame, returns the block to its reset values immediately. The partial frame is abandoned; the framer's own reset discards it.

## Test plan
- Requester 0 only, 3-beat frame, ready=1:
  - o_grant=01 in the cycle after ARB.
  - Beats out on 3 consecutive cycles, with last on the 3rd.
  - o_axi_s0_ready is high only during those 3 cycles.
- Both requesters continuously valid, 2-beat frames, G=4: the frame order is 0,1,0,1 and there are exactly 5 idle cycles between each last beat and the next first beat.
- Backpressure: i_axi_m_ready toggles 1,0,1,0 during a 4-beat frame:
  - No beat is lost or duplicated.
  - The owner's ready mirrors i_axi_m_ready.
  - The other requester's ready stays 0.
- i_link_up drops after beat 2 of a 5-beat frame:
  - All 5 beats still complete.
  - The FSM then passes through GAP to IDLE.
  - A pending requester 1 is not granted until link_up returns, and is then granted 2 cycles later (IDLE→ARB→XFER).
- A non-last beat with keep=4'b0111 is forwarded as 4'b0111, and o_keep_err pulses for exactly 1 cycle.
- r_rst is asserted mid-frame: all outputs go to 0 immediately. After release, the next grant goes to requester 0 when both are requesting.

Source files
------------

// File: rtl/phy_tx_arbiter_if.sv
// AXI-stream bundle between two transmit requesters, the arbiter and the PHY framer.
// The master modport is the arbiter's view; the slave modport is the surrounding logic's view.
interface phy_tx_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = 4;

    logic              i_axi_s0_valid;
    logic              i_axi_s0_last;
    logic [KEEP_W-1:0] i_axi_s0_keep;
    logic [DATA_W-1:0] i_axi_s0_data;
    logic              o_axi_s0_ready;

    logic              i_axi_s1_valid;
    logic              i_axi_s1_last;
    logic [KEEP_W-1:0] i_axi_s1_keep;
    logic [DATA_W-1:0] i_axi_s1_data;
    logic              o_axi_s1_ready;

    logic              o_axi_m_valid;
    logic              o_axi_m_last;
    logic [KEEP_W-1:0] o_axi_m_keep;
    logic [DATA_W-1:0] o_axi_m_data;
    logic              i_axi_m_ready;

    modport master (
        input  i_axi_s0_valid, i_axi_s0_last, i_axi_s0_keep, i_axi_s0_data,
        output o_axi_s0_ready,
        input  i_axi_s1_valid, i_axi_s1_last, i_axi_s1_keep, i_axi_s1_data,
        output o_axi_s1_ready,
        output o_axi_m_valid, o_axi_m_last, o_axi_m_keep, o_axi_m_data,
        input  i_axi_m_ready
    );

    modport slave (
        output i_axi_s0_valid, i_axi_s0_last, i_axi_s0_keep, i_axi_s0_data,
        input  o_axi_s0_ready,
        output i_axi_s1_valid, i_axi_s1_last, i_axi_s1_keep, i_axi_s1_data,
        input  o_axi_s1_ready,
        input  o_axi_m_valid, o_axi_m_last, o_axi_m_keep, o_axi_m_data,
        output i_axi_m_ready
    );
endinterface

// File: rtl/phy_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the GT transmit stream between two requesters,
// with a post-frame idle gap for the framer and grants held off while the link is down.
module phy_tx_arbiter #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  r_rst,
    input  logic                  i_link_up,
    phy_tx_arbiter_if.master      bus,
    output logic [1:0]            o_grant,
    output logic                  o_keep_err
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned KEEP_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic               r_rr_ptr;
    logic [1:0]         r_owner;
    logic               r_keep_err;

    logic               w_m_valid;
    logic               w_m_last;
    logic [KEEP_W-1:0]  w_m_keep;
    logic [DATA_W-1:0]  w_m_data;
    logic               w_s0_ready;
    logic               w_s1_ready;
    logic               w_beat;
    logic               w_beat_last;
    logic               w_any_req;
    logic               w_win1;

    // Pass-through path: only the owner is connected, and only while a frame is in flight.
    always_comb begin
        w_m_valid  = 1'b0;
        w_m_last   = 1'b0;
        w_m_keep   = '0;
        w_m_data   = '0;
        w_s0_ready = 1'b0;
        w_s1_ready = 1'b0;
        if (r_state == S_XFER) begin
            if (r_owner[1]) begin
                w_m_valid  = bus.i_axi_s1_valid;
                w_m_last   = bus.i_axi_s1_last;
                w_m_keep   = bus.i_axi_s1_keep;
                w_m_data   = bus.i_axi_s1_data;
                w_s1_ready = bus.i_axi_m_ready;
            end else begin
                w_m_valid  = bus.i_axi_s0_valid;
                w_m_last   = bus.i_axi_s0_last;
                w_m_keep   = bus.i_axi_s0_keep;
                w_m_data   = bus.i_axi_s0_data;
                w_s0_ready = bus.i_axi_m_ready;
            end
        end
    end

    assign bus.o_axi_m_valid  = w_m_valid;
    assign bus.o_axi_m_last   = w_m_last;
    assign bus.o_axi_m_keep   = w_m_keep;
    assign bus.o_axi_m_data   = w_m_data;
    assign bus.o_axi_s0_ready = w_s0_ready;
    assign bus.o_axi_s1_ready = w_s1_ready;

    assign w_beat      = w_m_valid & bus.i_axi_m_ready;
    assign w_beat_last = w_beat & w_m_last;
    assign w_any_req   = bus.i_axi_s0_valid | bus.i_axi_s1_valid;
    // On contention the round-robin pointer breaks the tie.
    assign w_win1      = (bus.i_axi_s0_valid & bus.i_axi_s1_valid) ? r_rr_ptr : bus.i_axi_s1_valid;

    always_ff @(posedge i_clk or posedge r_rst) begin
        if (r_rst) begin
            r_state    <= S_IDLE;
            r_gap_cnt  <= '0;
            r_rr_ptr   <= 1'b0;
            r_owner    <= 2'b00;
            r_keep_err <= 1'b0;
        end else begin
            r_keep_err <= w_beat & ~w_m_last & (w_m_keep != '1);
            case (r_state)
                S_IDLE: begin
                    if (i_link_up) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (!i_link_up) begin
                        r_state <= S_IDLE;
                    end else if (w_any_req) begin
                        r_owner <= w_win1 ? 2'b10 : 2'b01;
                        r_state <= S_XFER;
                    end
                end
                // Link loss is deliberately ignored here; the frame always completes.
                S_XFER: begin
                    if (w_beat_last) begin
                        r_rr_ptr  <= ~r_owner[1];
                        r_owner   <= 2'b00;
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYCLES == 0) ? S_ARB : S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= i_link_up ? S_ARB : S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant    = r_owner;
    assign o_keep_err = r_keep_err;
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Randomised and directed bench for phy_tx_arbiter against a frame-level reference model.
module tb_phy_tx_arbiter;
    localparam int unsigned G = 4;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    logic       i_clk = 1'b0;
    logic       r_rst;
    logic       i_link_up;
    logic [1:0] o_grant;
    logic       o_keep_err;

    phy_tx_arbiter_if bus();

    phy_tx_arbiter #(.GAP_CYCLES(G)) dut (
        .i_clk      (i_clk),
        .r_rst      (r_rst),
        .i_link_up  (i_link_up),
        .bus        (bus.master),
        .o_grant    (o_grant),
        .o_keep_err (o_keep_err)
    );

    always #5 i_clk = ~i_clk;

    beat_t q0[$];
    beat_t q1[$];
    bit    en0, en1;
    logic  m_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int   model_ptr;
    logic [1:0] prev_g;
    bit   pv0, pv1, plink, prev_hs_last;
    bit   exp_kerr;
    bit   in_frame;
    int   last_end;
    bit   last_end_ok;
    int   grant_cyc;
    int   frame_order[$];
    int   gaps[$];
    int   hs_cycles[$];
    int   kerr_cnt;
    int   s0_ready_cnt;

    task automatic model_reset();
        model_ptr    = 0;
        prev_g       = 2'b00;
        pv0          = 1'b0;
        pv1          = 1'b0;
        plink        = 1'b0;
        prev_hs_last = 1'b0;
        exp_kerr     = 1'b0;
        in_frame     = 1'b0;
        last_end     = 0;
        last_end_ok  = 1'b0;
    endtask

    task automatic clear_logs();
        frame_order.delete();
        gaps.delete();
        hs_cycles.delete();
        kerr_cnt     = 0;
        s0_ready_cnt = 0;
    endtask

    task automatic push_frame(input int r, input int len, input bit rand_keep);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = rand_keep ? 4'($urandom) : 4'hF;
            b.last = (i == len - 1);
            if (r == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    // One clock cycle: drive requesters from their queues, check outputs against the model, advance.
    task automatic step();
        beat_t b0, b1, bo;
        bit v0, v1, expv, hs, hs_last;
        int idx, ew;
        logic [1:0] g;
        b0 = (q0.size() > 0) ? q0[0] : '0;
        b1 = (q1.size() > 0) ? q1[0] : '0;
        v0 = en0 && (q0.size() > 0);
        v1 = en1 && (q1.size() > 0);
        bus.i_axi_s0_valid = v0;
        bus.i_axi_s0_last  = b0.last;
        bus.i_axi_s0_keep  = b0.keep;
        bus.i_axi_s0_data  = b0.data;
        bus.i_axi_s1_valid = v1;
        bus.i_axi_s1_last  = b1.last;
        bus.i_axi_s1_keep  = b1.keep;
        bus.i_axi_s1_data  = b1.data;
        bus.i_axi_m_ready  = m_ready;
        #1;
        cyc++;
        idx = 0;
        g = o_grant;

        checks++;
        if (o_keep_err !== exp_kerr) begin
            errors++;
            $display("FAIL keep_err cyc=%0d got=%b exp=%b", cyc, o_keep_err, exp_kerr);
        end
        if (o_keep_err === 1'b1) kerr_cnt++;
        if (bus.o_axi_s0_ready === 1'b1) s0_ready_cnt++;

        checks++;
        if (!(g === 2'b00 || g === 2'b01 || g === 2'b10)) begin
            errors++;
            $display("FAIL grant_onehot cyc=%0d got=%b", cyc, g);
        end

        if (g === 2'b00) begin
            checks++;
            if ({bus.o_axi_m_valid, bus.o_axi_m_last, bus.o_axi_m_keep, bus.o_axi_m_data,
                 bus.o_axi_s0_ready, bus.o_axi_s1_ready} !== '0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d valid=%b last=%b keep=%h data=%h r0=%b r1=%b exp all 0",
                         cyc, bus.o_axi_m_valid, bus.o_axi_m_last, bus.o_axi_m_keep, bus.o_axi_m_data,
                         bus.o_axi_s0_ready, bus.o_axi_s1_ready);
            end
        end else begin
            idx  = g[1] ? 1 : 0;
            bo   = idx ? b1 : b0;
            expv = idx ? v1 : v0;
            checks++;
            if (bus.o_axi_m_valid !== expv ||
                (expv && {bus.o_axi_m_last, bus.o_axi_m_keep, bus.o_axi_m_data} !== bo)) begin
                errors++;
                $display("FAIL passthru cyc=%0d got v=%b %b/%h/%h exp v=%b %b/%h/%h", cyc,
                         bus.o_axi_m_valid, bus.o_axi_m_last, bus.o_axi_m_keep, bus.o_axi_m_data,
                         expv, bo.last, bo.keep, bo.data);
            end
            checks++;
            if (bus.o_axi_s0_ready !== ((idx == 0) ? m_ready : 1'b0) ||
                bus.o_axi_s1_ready !== ((idx == 1) ? m_ready : 1'b0)) begin
                errors++;
                $display("FAIL readies cyc=%0d owner=%0d got r0=%b r1=%b m_ready=%b",
                         cyc, idx, bus.o_axi_s0_ready, bus.o_axi_s1_ready, m_ready);
            end
        end

        if (prev_g === 2'b00 && g !== 2'b00) begin
            checks++;
            ew = (pv0 && pv1) ? model_ptr : (pv0 ? 0 : 1);
            if (!plink || !(pv0 || pv1) || idx != ew) begin
                errors++;
                $display("FAIL winner cyc=%0d got=%0d exp=%0d link=%b v0=%b v1=%b",
                         cyc, idx, ew, plink, pv0, pv1);
            end
            frame_order.push_back(idx);
            grant_cyc = cyc;
        end else if (prev_g !== 2'b00) begin
            checks++;
            if (prev_hs_last ? (g !== 2'b00) : (g !== prev_g)) begin
                errors++;
                $display("FAIL grant_hold cyc=%0d got=%b prev=%b after_last=%b", cyc, g, prev_g, prev_hs_last);
            end
        end

        hs      = (g !== 2'b00) && (bus.o_axi_m_valid === 1'b1) && (m_ready === 1'b1);
        hs_last = hs && (bus.o_axi_m_last === 1'b1);
        if (hs) begin
            hs_cycles.push_back(cyc);
            if (!in_frame && last_end_ok) begin
                checks++;
                if (cyc - last_end < int'(G) + 2) begin
                    errors++;
                    $display("FAIL frame_gap cyc=%0d got=%0d exp>=%0d", cyc, cyc - last_end, int'(G) + 2);
                end
                gaps.push_back(cyc - last_end - 1);
            end
            in_frame = !hs_last;
            if (hs_last) begin
                model_ptr   = 1 - idx;
                last_end    = cyc;
                last_end_ok = 1'b1;
            end
        end
        exp_kerr     = hs && (bus.o_axi_m_last === 1'b0) && (bus.o_axi_m_keep !== 4'hF);
        prev_g       = g;
        pv0          = v0;
        pv1          = v1;
        plink        = i_link_up;
        prev_hs_last = hs_last;

        @(posedge i_clk);
        #1;
        if (hs) begin
            if (idx == 0) q0.delete(0);
            else          q1.delete(0);
        end
    endtask

    task automatic run_until_empty(input int bound);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < bound) begin
            step();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d left0=%0d left1=%0d", cyc, q0.size(), q1.size());
        end
    endtask

    task automatic do_reset();
        en0   = 1'b0;
        en1   = 1'b0;
        r_rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge i_clk);
        #1;
        r_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        r_rst     = 1'b1;
        i_link_up = 1'b1;
        m_ready   = 1'b1;
        bus.i_axi_s0_valid = 1'b1; bus.i_axi_s0_last = 1'b0;
        bus.i_axi_s0_keep  = 4'hF; bus.i_axi_s0_data = 32'hA5A5_0001;
        bus.i_axi_s1_valid = 1'b1; bus.i_axi_s1_last = 1'b0;
        bus.i_axi_s1_keep  = 4'hF; bus.i_axi_s1_data = 32'hA5A5_0002;
        bus.i_axi_m_ready  = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_grant, o_keep_err, bus.o_axi_m_valid, bus.o_axi_m_last, bus.o_axi_m_keep, bus.o_axi_m_data,
             bus.o_axi_s0_ready, bus.o_axi_s1_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state grant=%b kerr=%b valid=%b data=%h r0=%b r1=%b exp all 0",
                     o_grant, o_keep_err, bus.o_axi_m_valid, bus.o_axi_m_data,
                     bus.o_axi_s0_ready, bus.o_axi_s1_ready);
        end
        r_rst = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int gstep = 0;
        clear_logs();
        push_frame(0, 3, 1'b0);
        en0 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (frame_order.size() > 0) begin
                gstep = n;
                break;
            end
        end
        checks++;
        if (gstep != 3) begin
            errors++;
            $display("FAIL single_grant_latency got_step=%0d exp=3", gstep);
        end
        run_until_empty(20);
        repeat (int'(G) + 3) step();
        checks++;
        if (hs_cycles.size() != 3 || hs_cycles[0] != grant_cyc || hs_cycles[2] != grant_cyc + 2) begin
            errors++;
            $display("FAIL single_beats got_n=%0d exp=3 consecutive from cyc %0d", hs_cycles.size(), grant_cyc);
        end
        checks++;
        if (s0_ready_cnt != 3 || frame_order.size() != 1) begin
            errors++;
            $display("FAIL single_ready got_ready_cycles=%0d grants=%0d exp 3/1", s0_ready_cnt, frame_order.size());
        end
    endtask

    task automatic test_alternate();
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            push_frame(0, 2, 1'b0);
            push_frame(1, 2, 1'b0);
        end
        en0 = 1'b1;
        en1 = 1'b1;
        m_ready = 1'b1;
        run_until_empty(200);
        checks++;
        if (frame_order.size() != 6) begin
            errors++;
            $display("FAIL alt_frames got=%0d exp=6", frame_order.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (frame_order[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL alt_order idx=%0d got=%0d exp=%0d", i, frame_order[i], i % 2);
                end
            end
        end
        checks++;
        if (gaps.size() != 5) begin
            errors++;
            $display("FAIL alt_gap_count got=%0d exp=5", gaps.size());
        end
        foreach (gaps[i]) begin
            checks++;
            if (gaps[i] != int'(G) + 1) begin
                errors++;
                $display("FAIL alt_gap idx=%0d got=%0d exp=%0d", i, gaps[i], int'(G) + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_logs();
        push_frame(0, 4, 1'b0);
        push_frame(1, 2, 1'b0);
        en0 = 1'b1;
        en1 = 1'b1;
        while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
            m_ready = (n % 2 == 0);
            step();
            n++;
        end
        m_ready = 1'b1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || hs_cycles.size() != 6) begin
            errors++;
            $display("FAIL backpressure_beats got=%0d exp=6 left0=%0d left1=%0d", hs_cycles.size(), q0.size(), q1.size());
        end
    endtask

    task automatic test_link_drop();
        int n = 0;
        int gstep = 0;
        int q1_before;
        clear_logs();
        m_ready   = 1'b1;
        i_link_up = 1'b1;
        en1 = 1'b0;
        en0 = 1'b1;
        push_frame(0, 5, 1'b0);
        while (hs_cycles.size() < 2 && n < 40) begin
            step();
            n++;
        end
        i_link_up = 1'b0;
        push_frame(1, 2, 1'b0);
        en1 = 1'b1;
        n = 0;
        while (q0.size() > 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (hs_cycles.size() != 5) begin
            errors++;
            $display("FAIL link_drop_beats got=%0d exp=5", hs_cycles.size());
        end
        q1_before = q1.size();
        repeat (12) step();
        checks++;
        if (q1.size() != q1_before || frame_order.size() != 1) begin
            errors++;
            $display("FAIL link_down_hold grants=%0d exp=1 q1=%0d exp=%0d", frame_order.size(), q1.size(), q1_before);
        end
        i_link_up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (frame_order.size() > 1) begin
                gstep = k;
                break;
            end
        end
        checks++;
        if (gstep != 3 || frame_order.size() < 2 || frame_order[1] != 1) begin
            errors++;
            $display("FAIL link_up_grant got_step=%0d exp=3 grants=%0d", gstep, frame_order.size());
        end
        run_until_empty(20);
    endtask

    task automatic test_keep_err();
        beat_t b;
        clear_logs();
        en0 = 1'b1;
        en1 = 1'b0;
        b.last = 1'b0; b.keep = 4'b0111; b.data = 32'h1111_0000; q0.push_back(b);
        b.last = 1'b0; b.keep = 4'b1111; b.data = 32'h2222_0000; q0.push_back(b);
        b.last = 1'b1; b.keep = 4'b0011; b.data = 32'h3333_0000; q0.push_back(b);
        run_until_empty(40);
        repeat (3) step();
        checks++;
        if (kerr_cnt != 1) begin
            errors++;
            $display("FAIL keep_err_pulses got=%0d exp=1", kerr_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        clear_logs();
        push_frame(0, 6, 1'b0);
        push_frame(1, 6, 1'b0);
        en0 = 1'b1;
        en1 = 1'b1;
        m_ready = 1'b1;
        while (hs_cycles.size() < 2 && n < 40) begin
            step();
            n++;
        end
        #2;
        r_rst = 1'b1;
        #1;
        checks++;
        if ({o_grant, o_keep_err, bus.o_axi_m_valid, bus.o_axi_m_last, bus.o_axi_m_keep, bus.o_axi_m_data,
             bus.o_axi_s0_ready, bus.o_axi_s1_ready} !== '0) begin
            errors++;
            $display("FAIL reset_midframe grant=%b valid=%b data=%h r0=%b r1=%b exp all 0",
                     o_grant, bus.o_axi_m_valid, bus.o_axi_m_data, bus.o_axi_s0_ready, bus.o_axi_s1_ready);
        end
        @(posedge i_clk);
        #1;
        q0.delete();
        q1.delete();
        r_rst = 1'b0;
        model_reset();
        clear_logs();
        push_frame(0, 2, 1'b0);
        push_frame(1, 2, 1'b0);
        run_until_empty(60);
        checks++;
        if (frame_order.size() == 0 || frame_order[0] != 0) begin
            errors++;
            $display("FAIL reset_rr_ptr got_first=%0d exp=0", (frame_order.size() > 0) ? frame_order[0] : -1);
        end
    endtask

    task automatic test_random();
        do_reset();
        clear_logs();
        for (int n = 0; n < 600; n++) begin
            if (q0.size() < 6 && $urandom_range(0, 9) < 3) push_frame(0, int'($urandom_range(1, 5)), 1'b1);
            if (q1.size() < 6 && $urandom_range(0, 9) < 3) push_frame(1, int'($urandom_range(1, 5)), 1'b1);
            en0       = ($urandom_range(0, 99) < 85);
            en1       = ($urandom_range(0, 99) < 85);
            m_ready   = ($urandom_range(0, 99) < 75);
            i_link_up = ($urandom_range(0, 99) < 95);
            step();
        end
        en0 = 1'b1;
        en1 = 1'b1;
        m_ready = 1'b1;
        i_link_up = 1'b1;
        run_until_empty(1000);
        checks++;
        if (frame_order.size() < 10) begin
            errors++;
            $display("FAIL random_activity got_grants=%0d exp>=10", frame_order.size());
        end
    endtask

    initial begin
        en0 = 1'b0;
        en1 = 1'b0;
        clear_logs();
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_link_drop();
        test_keep_err();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
